// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - opcode fetch and microcode ROM stepping with memory req/ack arbitration
module microcode_sequencer #(
  parameter int CW_WIDTH  = 60,
  parameter int MAX_STEPS = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic                o_fetch_req,
  input  logic                i_fetch_ack,
  input  logic [7:0]          i_fetch_data,
  output logic [7:0]          o_rom_addr,
  input  logic [CW_WIDTH-1:0] i_rom_word,
  output logic [49:0]         o_ctrl_out,
  output logic                o_ctrl_valid,
  output logic                o_mem_req,
  input  logic                i_mem_ack,
  input  logic                i_stall,
  output logic [7:0]          o_cur_opcode,
  output logic                o_instr_done,
  output logic                o_step_err
);

  localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_uaddr;
  logic [SW-1:0] r_step;
  logic [7:0]    r_cur_opcode;
  logic          r_step_err;

  state_t        w_state_nxt;
  logic [7:0]    w_uaddr_nxt;
  logic [SW-1:0] w_step_nxt;
  logic [7:0]    w_opcode_nxt;
  logic          w_err_nxt;
  logic          w_fire;
  logic          w_done;
  logic          w_mem_req;
  logic          w_fetch_req;

  logic          w_cw_end;
  logic          w_cw_mem;
  logic [7:0]    w_cw_next;

  assign w_cw_end  = i_rom_word[59];
  assign w_cw_mem  = i_rom_word[58];
  assign w_cw_next = i_rom_word[57:50];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_uaddr      <= 8'h00;
      r_step       <= '0;
      r_cur_opcode <= 8'h00;
      r_step_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_uaddr      <= w_uaddr_nxt;
      r_step       <= w_step_nxt;
      r_cur_opcode <= w_opcode_nxt;
      r_step_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_uaddr_nxt  = r_uaddr;
    w_step_nxt   = r_step;
    w_opcode_nxt = r_cur_opcode;
    w_err_nxt    = r_step_err;
    w_fire       = 1'b0;
    w_done       = 1'b0;
    w_mem_req    = 1'b0;
    w_fetch_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (i_fetch_ack) begin
          w_opcode_nxt = i_fetch_data;
          w_uaddr_nxt  = i_fetch_data;
          w_step_nxt   = '0;
          w_state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        // mem_req is masked by stall so the memory side never completes a cycle we won't consume
        w_mem_req = w_cw_mem & ~i_stall;
        w_fire    = ~i_stall & (~w_cw_mem | i_mem_ack);
        if (w_fire) begin
          if (w_cw_end) begin
            w_done      = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_uaddr_nxt = w_cw_next;
            if (r_step == STEP_LAST) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_FETCH;
            end else begin
              w_step_nxt = r_step + 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_fetch_req  = w_fetch_req;
  assign o_rom_addr   = r_uaddr;
  assign o_ctrl_out   = i_rom_word[49:0];
  assign o_ctrl_valid = w_fire;
  assign o_mem_req    = w_mem_req;
  assign o_cur_opcode = r_cur_opcode;
  assign o_instr_done = w_done;
  assign o_step_err   = r_step_err;

endmodule
